// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - fills Memory from a byte stream at addresses 0..load_len-1, holding the CPU until done
// Optional trailing checksum byte validation: define MEM_LOADER_CHECKSUM_EN
module mem_loader #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_load,
   input  logic [6:0]        load_len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] adr_bus,
   output logic [DATA_W-1:0] data_bus_out,
   output logic              wr_mem,
   output logic              bus_own,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   localparam logic [6:0] MAX_LEN = 7'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
`ifdef MEM_LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_FINISH,
      S_RUN
   } state_t;

   state_t            state, state_n;
   logic [6:0]        len, len_n;
   logic [6:0]        cnt, cnt_n;
   logic              in_ready_n, wr_mem_n, bus_own_n, cpu_hold_n, done_n, err_n;
   logic [ADDR_W-1:0] adr_n;
   logic [DATA_W-1:0] data_n;
   logic              accept, len_ok;
`ifdef MEM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum, sum_n;
`endif

   assign accept = in_valid && in_ready;
   assign len_ok = (load_len != 7'd0) && (load_len <= MAX_LEN);

   always_comb begin
      state_n    = state;
      len_n      = len;
      cnt_n      = cnt;
      in_ready_n = in_ready;
      adr_n      = adr_bus;
      data_n     = data_bus_out;
      wr_mem_n   = 1'b0;
      bus_own_n  = bus_own;
      cpu_hold_n = cpu_hold;
      done_n     = done;
      err_n      = err;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_n      = sum;
`endif
      case (state)
         S_IDLE, S_RUN: begin
            if (start_load) begin
               if (len_ok) begin
                  state_n    = S_LOAD;
                  len_n      = load_len;
                  cnt_n      = 7'd0;
                  done_n     = 1'b0;
                  err_n      = 1'b0;
                  in_ready_n = 1'b1;
                  bus_own_n  = 1'b1;
                  cpu_hold_n = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
                  sum_n      = '0;
`endif
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               wr_mem_n = 1'b1;
               adr_n    = cnt[ADDR_W-1:0];
               data_n   = in_data;
               cnt_n    = cnt + 7'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
               sum_n    = sum + in_data;
               if (cnt + 7'd1 == len) state_n = S_CHK;
`else
               if (cnt + 7'd1 == len) begin
                  state_n    = S_FINISH;
                  in_ready_n = 1'b0;
               end
`endif
            end
         end
`ifdef MEM_LOADER_CHECKSUM_EN
         // The checksum byte is consumed but never written to Memory.
         S_CHK: begin
            if (accept) begin
               in_ready_n = 1'b0;
               if (in_data == sum) begin
                  state_n = S_FINISH;
               end else begin
                  state_n   = S_IDLE;
                  err_n     = 1'b1;
                  bus_own_n = 1'b0;
               end
            end
         end
`endif
         S_FINISH: begin
            state_n    = S_RUN;
            bus_own_n  = 1'b0;
            cpu_hold_n = 1'b0;
            done_n     = 1'b1;
            in_ready_n = 1'b0;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         len          <= 7'd0;
         cnt          <= 7'd0;
         in_ready     <= 1'b0;
         adr_bus      <= '0;
         data_bus_out <= '0;
         wr_mem       <= 1'b0;
         bus_own      <= 1'b0;
         cpu_hold     <= 1'b1;
         done         <= 1'b0;
         err          <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
         sum          <= '0;
`endif
      end else begin
         state        <= state_n;
         len          <= len_n;
         cnt          <= cnt_n;
         in_ready     <= in_ready_n;
         adr_bus      <= adr_n;
         data_bus_out <= data_n;
         wr_mem       <= wr_mem_n;
         bus_own      <= bus_own_n;
         cpu_hold     <= cpu_hold_n;
         done         <= done_n;
         err          <= err_n;
`ifdef MEM_LOADER_CHECKSUM_EN
         sum          <= sum_n;
`endif
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - self-checking bench for mem_loader with a Memory model and write scoreboard
module tb_mem_loader;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 64;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start_load = 1'b0;
   logic [6:0]        load_len = 7'd0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready, wr_mem, bus_own, cpu_hold, done, err;
   logic [ADDR_W-1:0] adr_bus;
   logic [DATA_W-1:0] data_bus_out;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [ADDR_W-1:0] adr;
      logic [DATA_W-1:0] data;
   } wr_t;

   typedef struct {
      logic [6:0] len;
      logic       exp_err;
      logic       exp_rdy;
      logic       exp_own;
   } vec_t;

   wr_t               exp_q[$];
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] src [DEPTH+1];
   logic [ADDR_W-1:0] last_adr;
   logic [DATA_W-1:0] last_data;
   vec_t              vecs [5];

   mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start_load(start_load), .load_len(load_len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .adr_bus(adr_bus), .data_bus_out(data_bus_out), .wr_mem(wr_mem),
      .bus_own(bus_own), .cpu_hold(cpu_hold), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   // Memory model: samples the write port on the rising edge, like the real Memory.
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      forever begin
         @(posedge clk);
         if (reset && wr_mem && bus_own) mem[adr_bus] = data_bus_out;
      end
   end

   // Scoreboard: each accepted byte must be written on the cycle right after its accept edge.
   initial begin
      last_adr = '0;
      last_data = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            exp_q.delete();
            last_adr = '0;
            last_data = '0;
         end else if (exp_q.size() > 0) begin
            check("wr_strobe", 32'(wr_mem), 32'd1);
            check("wr_adr", 32'(adr_bus), 32'(exp_q[0].adr));
            check("wr_data", 32'(data_bus_out), 32'(exp_q[0].data));
            last_adr = exp_q[0].adr;
            last_data = exp_q[0].data;
            void'(exp_q.pop_front());
         end else begin
            check("no_wr", 32'(wr_mem), 32'd0);
            check("hold_adr", 32'(adr_bus), 32'(last_adr));
            check("hold_data", 32'(data_bus_out), 32'(last_data));
         end
      end
   end

   // mode 0: back-to-back, 1: valid toggles 1,0, 2: random bubbles
   task automatic do_load(input int len, input int mode, input bit bad_ck);
      int total, idx, guard;
      bit acc;
      logic [DATA_W-1:0] sum;
      sum = '0;
      for (int i = 0; i < len; i++) sum = sum + src[i];
      src[len] = bad_ck ? sum + 8'd1 : sum;
`ifdef MEM_LOADER_CHECKSUM_EN
      total = len + 1;
`else
      total = len;
`endif
      load_len = 7'(len);
      start_load = 1'b1;
      tick();
      start_load = 1'b0;
      check("hold_after_start", 32'(cpu_hold), 32'd1);
      check("own_after_start", 32'(bus_own), 32'd1);
      check("ready_in_load", 32'(in_ready), 32'd1);
      check("done_cleared", 32'(done), 32'd0);
      check("err_cleared", 32'(err), 32'd0);
      idx = 0;
      guard = 0;
      while (idx < total && guard < 400) begin
         case (mode)
            0: in_valid = 1'b1;
            1: in_valid = (guard % 2 == 0);
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         in_data = src[idx];
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            if (idx < len) exp_q.push_back('{adr: ADDR_W'(idx), data: src[idx]});
            idx++;
         end
         guard++;
      end
      in_valid = 1'b0;
      if (idx < total) check("load_timeout", 32'(idx), 32'(total));
      check("ready_dropped", 32'(in_ready), 32'd0);
   endtask

   task automatic finish_check(input bit ok, input int len);
      int n;
      n = 0;
      while (!(done || err) && n < 20) begin
         tick();
         n++;
      end
      check("done", 32'(done), 32'(ok));
      check("err", 32'(err), 32'(!ok));
      check("cpu_hold", 32'(cpu_hold), 32'(!ok));
      check("bus_own", 32'(bus_own), 32'd0);
      check("in_ready_end", 32'(in_ready), 32'd0);
      if (ok)
         for (int i = 0; i < len; i++) check("mem", 32'(mem[i]), 32'(src[i]));
   endtask

   initial begin
      vecs[0] = '{len: 7'd0,   exp_err: 1'b1, exp_rdy: 1'b0, exp_own: 1'b0};
      vecs[1] = '{len: 7'd65,  exp_err: 1'b1, exp_rdy: 1'b0, exp_own: 1'b0};
      vecs[2] = '{len: 7'd127, exp_err: 1'b1, exp_rdy: 1'b0, exp_own: 1'b0};
      vecs[3] = '{len: 7'd1,   exp_err: 1'b0, exp_rdy: 1'b1, exp_own: 1'b1};
      vecs[4] = '{len: 7'd64,  exp_err: 1'b0, exp_rdy: 1'b1, exp_own: 1'b1};

      tick();
      tick();
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_adr", 32'(adr_bus), 32'd0);
      check("rst_data", 32'(data_bus_out), 32'd0);
      check("rst_wr", 32'(wr_mem), 32'd0);
      check("rst_own", 32'(bus_own), 32'd0);
      check("rst_hold", 32'(cpu_hold), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      reset = 1'b1;
      tick();

      for (int v = 0; v < 5; v++) begin
         pulse_reset();
         load_len = vecs[v].len;
         start_load = 1'b1;
         tick();
         start_load = 1'b0;
         check("vec_err", 32'(err), 32'(vecs[v].exp_err));
         check("vec_ready", 32'(in_ready), 32'(vecs[v].exp_rdy));
         check("vec_own", 32'(bus_own), 32'(vecs[v].exp_own));
         check("vec_hold", 32'(cpu_hold), 32'd1);
         tick();
         check("vec_ready_stable", 32'(in_ready), 32'(vecs[v].exp_rdy));
         check("vec_wr", 32'(wr_mem), 32'd0);
      end
      pulse_reset();

      src[0] = 8'hA1; src[1] = 8'hB2; src[2] = 8'hC3; src[3] = 8'hD4;
      do_load(4, 0, 1'b0);
      finish_check(1'b1, 4);

      for (int i = 0; i < DEPTH; i++) src[i] = 8'($urandom);
      do_load(64, 1, 1'b0);
      finish_check(1'b1, 64);

      load_len = 7'd0;
      start_load = 1'b1;
      tick();
      start_load = 1'b0;
      check("run_bad_len_err", 32'(err), 32'd1);
      check("run_bad_len_hold", 32'(cpu_hold), 32'd0);
      check("run_bad_len_ready", 32'(in_ready), 32'd0);

      for (int r = 0; r < 6; r++) begin
         int len;
         len = int'($urandom_range(1, 64));
         for (int i = 0; i < len; i++) src[i] = 8'($urandom);
         do_load(len, int'($urandom_range(0, 2)), 1'b0);
         finish_check(1'b1, len);
      end

`ifdef MEM_LOADER_CHECKSUM_EN
      src[0] = 8'h10; src[1] = 8'h20;
      do_load(2, 0, 1'b0);
      check("ck_byte_good", 32'(src[2]), 32'h30);
      finish_check(1'b1, 2);
      do_load(2, 0, 1'b1);
      finish_check(1'b0, 2);
      tick();
      check("ck_bad_stays_idle", 32'(in_ready), 32'd0);
      check("ck_bad_hold", 32'(cpu_hold), 32'd1);
`endif

      for (int i = 0; i < 8; i++) src[i] = 8'hE1 + 8'(i);
      load_len = 7'd8;
      start_load = 1'b1;
      tick();
      start_load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data = src[i];
         tick();
         exp_q.push_back('{adr: ADDR_W'(i), data: src[i]});
      end
      in_valid = 1'b0;
      tick();
      #2 reset = 1'b0;
      #1;
      check("arst_hold", 32'(cpu_hold), 32'd1);
      check("arst_ready", 32'(in_ready), 32'd0);
      check("arst_wr", 32'(wr_mem), 32'd0);
      check("arst_own", 32'(bus_own), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_adr", 32'(adr_bus), 32'd0);
      for (int i = 0; i < 3; i++) check("arst_mem", 32'(mem[i]), 32'(src[i]));
      tick();
      reset = 1'b1;
      tick();
      src[0] = 8'h5A; src[1] = 8'hC7;
      do_load(2, 0, 1'b0);
      finish_check(1'b1, 2);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
